// File: rtl/bcd_countdown_timer_if.sv
// +------------------------------------------------------------------+
// | bcd_countdown_timer_if: command/status bundle of the mm:ss timer |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

interface bcd_countdown_timer_if;
  logic        i_tick;
  logic        i_clear;
  logic        i_load;
  logic [15:0] i_load_value;
  logic        i_start;
  logic        i_pause;
  logic [15:0] o_digits;
  logic [1:0]  o_state;
  logic        o_transition;
  logic        o_done;
  logic        o_expired;

  modport master (
    output i_tick, i_clear, i_load, i_load_value, i_start, i_pause,
    input  o_digits, o_state, o_transition, o_done, o_expired
  );

  modport slave (
    input  i_tick, i_clear, i_load, i_load_value, i_start, i_pause,
    output o_digits, o_state, o_transition, o_done, o_expired
  );
endinterface

`default_nettype wire

// File: rtl/bcd_countdown_timer.sv
// +------------------------------------------------------------------+
// | bcd_countdown_timer: four-digit BCD mm:ss countdown with expiry  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module bcd_countdown_timer #(
  parameter int TENS_MAX = 5,
  parameter int ONES_MAX = 9
) (
  input  wire logic           i_clk,
  input  wire logic           i_rst_n,
  bcd_countdown_timer_if.slave bus
);

  localparam logic [3:0] c_TENS_MAX = 4'(TENS_MAX);
  localparam logic [3:0] c_ONES_MAX = 4'(ONES_MAX);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t      r_state;
  logic [15:0] r_digits;
  logic        r_transition;
  logic        r_done;

  state_t      w_next_state;
  logic [15:0] w_next_digits;
  logic        w_next_transition;
  logic        w_next_done;

  logic [3:0]  w_so, w_st, w_mo, w_mt;
  logic        w_b0, w_b1, w_b2;
  logic [15:0] w_dec;

  function automatic logic [15:0] f_clamp(input logic [15:0] v);
    logic [15:0] r;
    r[15:12] = (v[15:12] > c_TENS_MAX) ? c_TENS_MAX : v[15:12];
    r[11:8]  = (v[11:8]  > c_ONES_MAX) ? c_ONES_MAX : v[11:8];
    r[7:4]   = (v[7:4]   > c_TENS_MAX) ? c_TENS_MAX : v[7:4];
    r[3:0]   = (v[3:0]   > c_ONES_MAX) ? c_ONES_MAX : v[3:0];
    return r;
  endfunction

  // Borrow chain: each digit steps only when every digit below it wrapped.
  always_comb begin
    w_so = r_digits[3:0];
    w_st = r_digits[7:4];
    w_mo = r_digits[11:8];
    w_mt = r_digits[15:12];
    w_b0 = (w_so == 4'd0);
    w_b1 = w_b0 && (w_st == 4'd0);
    w_b2 = w_b1 && (w_mo == 4'd0);
    w_dec[3:0]   = w_b0 ? c_ONES_MAX : w_so - 4'd1;
    w_dec[7:4]   = w_b0 ? (w_b1 ? c_TENS_MAX : w_st - 4'd1) : w_st;
    w_dec[11:8]  = w_b1 ? (w_b2 ? c_ONES_MAX : w_mo - 4'd1) : w_mo;
    w_dec[15:12] = w_b2 ? w_mt - 4'd1 : w_mt;
  end

  always_comb begin
    w_next_state      = r_state;
    w_next_digits     = r_digits;
    w_next_transition = 1'b0;
    w_next_done       = 1'b0;
    if (bus.i_clear) begin
      w_next_state  = ST_IDLE;
      w_next_digits = 16'h0000;
    end else if (bus.i_load && (r_state != ST_RUN)) begin
      w_next_digits = f_clamp(bus.i_load_value);
      if (r_state == ST_DONE) w_next_state = ST_IDLE;
    end else if (bus.i_pause && (r_state == ST_RUN)) begin
      w_next_state = ST_PAUSED;
    end else if (bus.i_start && ((r_state == ST_IDLE) || (r_state == ST_PAUSED))
                 && (r_digits != 16'h0000)) begin
      w_next_state = ST_RUN;
    end else if (bus.i_tick && (r_state == ST_RUN)) begin
      w_next_digits     = w_dec;
      w_next_transition = w_b1;
      if (w_dec == 16'h0000) begin
        w_next_state = ST_DONE;
        w_next_done  = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= ST_IDLE;
      r_digits     <= 16'h0000;
      r_transition <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_state      <= w_next_state;
      r_digits     <= w_next_digits;
      r_transition <= w_next_transition;
      r_done       <= w_next_done;
    end
  end

  assign bus.o_digits     = r_digits;
  assign bus.o_state      = r_state;
  assign bus.o_transition = r_transition;
  assign bus.o_done       = r_done;
  assign bus.o_expired    = (r_state == ST_DONE);

endmodule

`default_nettype wire

// File: tb/tb_bcd_countdown_timer.sv
// +------------------------------------------------------------------+
// | tb_bcd_countdown_timer: directed self-checking bench             |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module tb_bcd_countdown_timer;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  bcd_countdown_timer_if bus();

  bcd_countdown_timer #(.TENS_MAX(5), .ONES_MAX(9)) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_load(input logic [15:0] v);
    bus.i_load = 1'b1; bus.i_load_value = v;
    step();
    bus.i_load = 1'b0;
  endtask

  task automatic pulse_start();
    bus.i_start = 1'b1;
    step();
    bus.i_start = 1'b0;
  endtask

  task automatic pulse_tick();
    bus.i_tick = 1'b1;
    step();
    bus.i_tick = 1'b0;
  endtask

  task automatic pulse_clear();
    bus.i_clear = 1'b1;
    step();
    bus.i_clear = 1'b0;
  endtask

  initial begin
    logic [15:0] exp_seq [5];
    vectors = 0;
    miscompares = 0;
    rst_n = 1'b0;
    bus.i_tick = 1'b0; bus.i_clear = 1'b0; bus.i_load = 1'b0;
    bus.i_load_value = 16'h0000; bus.i_start = 1'b0; bus.i_pause = 1'b0;

    #23;
    check("rst_digits", bus.o_digits, 16'h0000);
    check("rst_state", 16'(bus.o_state), 16'd0);
    check("rst_trans", 16'(bus.o_transition), 16'd0);
    check("rst_done", 16'(bus.o_done), 16'd0);
    check("rst_expired", 16'(bus.o_expired), 16'd0);
    rst_n = 1'b1;
    step();

    // 01:05 counting down across a minute boundary
    pulse_load(16'h0105);
    check("load0105", bus.o_digits, 16'h0105);
    check("load0105_state", 16'(bus.o_state), 16'd0);
    pulse_start();
    check("start_run", 16'(bus.o_state), 16'd1);
    exp_seq = '{16'h0104, 16'h0103, 16'h0102, 16'h0101, 16'h0100};
    for (int k = 0; k < 5; k++) begin
      pulse_tick();
      check("tick_digits", bus.o_digits, exp_seq[k]);
      check("tick_no_trans", 16'(bus.o_transition), 16'd0);
    end
    pulse_tick();
    check("borrow_0059", bus.o_digits, 16'h0059);
    check("borrow_trans", 16'(bus.o_transition), 16'd1);
    step();
    check("trans_one_cycle", 16'(bus.o_transition), 16'd0);

    // Expiry
    pulse_clear();
    pulse_load(16'h0003);
    pulse_start();
    pulse_tick();
    check("exp_0002", bus.o_digits, 16'h0002);
    pulse_tick();
    check("exp_0001", bus.o_digits, 16'h0001);
    check("exp_no_done_yet", 16'(bus.o_done), 16'd0);
    pulse_tick();
    check("exp_0000", bus.o_digits, 16'h0000);
    check("exp_done", 16'(bus.o_done), 16'd1);
    check("exp_state", 16'(bus.o_state), 16'd3);
    check("exp_expired", 16'(bus.o_expired), 16'd1);
    check("exp_no_trans", 16'(bus.o_transition), 16'd0);
    pulse_tick();
    check("done_hold_digits", bus.o_digits, 16'h0000);
    check("done_one_pulse", 16'(bus.o_done), 16'd0);
    check("expired_level", 16'(bus.o_expired), 16'd1);

    // 10:00 -> 09:59 full ripple, and clamp
    pulse_load(16'h1000);
    check("done_load_idle", 16'(bus.o_state), 16'd0);
    check("done_load_expired", 16'(bus.o_expired), 16'd0);
    pulse_start();
    pulse_tick();
    check("ripple_0959", bus.o_digits, 16'h0959);
    check("ripple_trans", 16'(bus.o_transition), 16'd1);
    pulse_clear();
    pulse_load(16'hFFFF);
    check("clamp_ffff", bus.o_digits, 16'h5959);
    pulse_load(16'h7A3C);
    check("clamp_mixed", bus.o_digits, 16'h5939);

    // Pause beats tick; paused loads
    pulse_load(16'h0230);
    pulse_start();
    bus.i_pause = 1'b1; bus.i_tick = 1'b1;
    step();
    bus.i_pause = 1'b0; bus.i_tick = 1'b0;
    check("pause_state", 16'(bus.o_state), 16'd2);
    check("pause_digits", bus.o_digits, 16'h0230);
    for (int k = 0; k < 3; k++) pulse_tick();
    check("paused_ticks", bus.o_digits, 16'h0230);
    pulse_load(16'h0010);
    check("paused_load", bus.o_digits, 16'h0010);
    check("paused_load_state", 16'(bus.o_state), 16'd2);
    pulse_start();
    check("resume_state", 16'(bus.o_state), 16'd1);
    pulse_tick();
    check("resume_0009", bus.o_digits, 16'h0009);

    // Start at zero, load in RUN, clear beats start
    pulse_clear();
    check("clear_idle", 16'(bus.o_state), 16'd0);
    pulse_start();
    check("zero_start_state", 16'(bus.o_state), 16'd0);
    check("zero_start_done", 16'(bus.o_done), 16'd0);
    pulse_load(16'h0500);
    pulse_start();
    pulse_load(16'h0123);
    check("run_load_ignored", bus.o_digits, 16'h0500);
    check("run_load_state", 16'(bus.o_state), 16'd1);
    bus.i_clear = 1'b1; bus.i_start = 1'b1;
    step();
    bus.i_clear = 1'b0; bus.i_start = 1'b0;
    check("clear_start_digits", bus.o_digits, 16'h0000);
    check("clear_start_state", 16'(bus.o_state), 16'd0);

    // Asynchronous reset mid-count
    pulse_clear();
    pulse_load(16'h0312);
    pulse_start();
    check("pre_rst_run", 16'(bus.o_state), 16'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("arst_digits", bus.o_digits, 16'h0000);
    check("arst_state", 16'(bus.o_state), 16'd0);
    check("arst_trans", 16'(bus.o_transition), 16'd0);
    check("arst_done", 16'(bus.o_done), 16'd0);
    check("arst_expired", 16'(bus.o_expired), 16'd0);
    #1;
    rst_n = 1'b1;
    step();
    check("post_rst_digits", bus.o_digits, 16'h0000);
    check("post_rst_state", 16'(bus.o_state), 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
